fetch_rf_1p_masked: RTL and testbench

FETCH_RF_1P_MASKED -- requirements
Module: fetch_rf_1p_masked

---
 rtl/fetch_rf_1p_masked_if.sv | 29 ++
 rtl/fetch_rf_1p_masked.sv | 127 ++++++++++++
 tb/tb_fetch_rf_1p_masked.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_rf_1p_masked_if.sv
// rtl/fetch_rf_1p_masked_if.sv - write/read request bus for the masked single-port pixel register file
interface fetch_rf_1p_masked_if #(
  parameter int PIXEL_WIDTH = 8,
  parameter int PIX_NUM     = 48,
  parameter int ADDR_W      = 6
);
  localparam int W = PIX_NUM * PIXEL_WIDTH;

  logic              wr_en_i;
  logic [ADDR_W-1:0] wr_addr_i;
  logic [PIX_NUM-1:0] wr_mask_i;
  logic [W-1:0]      wr_data_i;
  logic              wr_rdy_o;
  logic              rd_en_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic              rd_rdy_o;
  logic              rd_vld_o;
  logic [W-1:0]      rd_data_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_mask_i, wr_data_i, rd_en_i, rd_addr_i,
    input  wr_rdy_o, rd_rdy_o, rd_vld_o, rd_data_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_mask_i, wr_data_i, rd_en_i, rd_addr_i,
    output wr_rdy_o, rd_rdy_o, rd_vld_o, rd_data_o
  );
endinterface

// File: rtl/fetch_rf_1p_masked.sv
// rtl/fetch_rf_1p_masked.sv - single-port pixel register file with per-pixel masked writes
module fetch_rf_1p_masked #(
  parameter int PIXEL_WIDTH = 8,
  parameter int PIX_NUM     = 48,
  parameter int ADDR_W      = 6,
  parameter int DEPTH       = 64
) (
  input  logic clk,
  input  logic rstn,
  fetch_rf_1p_masked_if.slave bus
);
  localparam int W = PIX_NUM * PIXEL_WIDTH;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  typedef enum logic {IDLE, RMW} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [W-1:0]        r_mem [DEPTH];
  logic [W-1:0]        r_q;
  logic [W-1:0]        r_hold;
  logic                r_rd_vld;
  logic                r_rd_oor;
  logic [ADDR_W-1:0]   r_addr;
  logic [PIX_NUM-1:0]  r_mask;
  logic [W-1:0]        r_data;

  logic                w_wr_rdy;
  logic                w_rd_rdy;
  logic                w_wr_acc;
  logic                w_rd_acc;
  logic                w_wr_in;
  logic                w_rd_in;
  logic                w_full;
  logic                w_partial;
  logic                w_ren;
  logic                w_wen;
  logic [ADDR_W-1:0]   w_addr;
  logic [W-1:0]        w_wdata;
  logic [W-1:0]        w_merge;
  logic [W-1:0]        w_rd_word;

  assign w_wr_in   = ({1'b0, bus.wr_addr_i} < DEPTH_C);
  assign w_rd_in   = ({1'b0, bus.rd_addr_i} < DEPTH_C);
  assign w_full    = &bus.wr_mask_i;
  assign w_partial = (|bus.wr_mask_i) & ~w_full;

  // Shared single array port: RMW completion, then accepted write, then accepted read.
  always_comb begin
    w_next   = r_state;
    w_wr_rdy = 1'b0;
    w_rd_rdy = 1'b0;
    w_wr_acc = 1'b0;
    w_rd_acc = 1'b0;
    w_ren    = 1'b0;
    w_wen    = 1'b0;
    w_addr   = bus.rd_addr_i;
    w_wdata  = bus.wr_data_i;
    case (r_state)
      IDLE: begin
        w_wr_rdy = ~rstn;
        w_rd_rdy = ~rstn & ~bus.wr_en_i;
        w_wr_acc = bus.wr_en_i & w_wr_rdy;
        w_rd_acc = bus.rd_en_i & w_rd_rdy;
        if (w_wr_acc) begin
          w_addr = bus.wr_addr_i;
          if (w_wr_in && w_full) begin
            w_wen = 1'b1;
          end else if (w_wr_in && w_partial) begin
            w_ren  = 1'b1;
            w_next = RMW;
          end
        end else if (w_rd_acc && w_rd_in) begin
          w_ren = 1'b1;
        end
      end
      RMW: begin
        w_next  = IDLE;
        w_addr  = r_addr;
        w_wdata = w_merge;
        w_wen   = ~rstn;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_merge = r_q;
    for (int k = 0; k < PIX_NUM; k++) begin
      if (r_mask[k]) w_merge[k*PIXEL_WIDTH +: PIXEL_WIDTH] = r_data[k*PIXEL_WIDTH +: PIXEL_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (w_wen) r_mem[w_addr] <= w_wdata;
    if (w_ren) r_q <= r_mem[w_addr];
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state  <= IDLE;
      r_rd_vld <= 1'b0;
      r_rd_oor <= 1'b0;
      r_hold   <= '0;
      r_addr   <= '0;
      r_mask   <= '0;
      r_data   <= '0;
    end else begin
      r_state  <= w_next;
      r_rd_vld <= w_rd_acc;
      if (w_rd_acc) r_rd_oor <= ~w_rd_in;
      if (r_rd_vld) r_hold <= w_rd_word;
      if (w_wr_acc && w_wr_in && w_partial) begin
        r_addr <= bus.wr_addr_i;
        r_mask <= bus.wr_mask_i;
        r_data <= bus.wr_data_i;
      end
    end
  end

  // r_q also carries RMW reads, so the visible word comes from r_hold unless a read just landed.
  assign w_rd_word     = r_rd_oor ? '0 : r_q;
  assign bus.wr_rdy_o  = w_wr_rdy;
  assign bus.rd_rdy_o  = w_rd_rdy;
  assign bus.rd_vld_o  = r_rd_vld & ~rstn;
  assign bus.rd_data_o = rstn ? '0 : (r_rd_vld ? w_rd_word : r_hold);
endmodule

// File: tb/tb_fetch_rf_1p_masked.sv
// tb/tb_fetch_rf_1p_masked.sv - directed table-driven bench for fetch_rf_1p_masked
module tb_fetch_rf_1p_masked;
  localparam int PW = 8;
  localparam int PN = 48;
  localparam int AW = 6;
  localparam int W  = PW * PN;
  localparam logic [PN-1:0] M_ALL = '1;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_rf_1p_masked_if #(.PIXEL_WIDTH(PW), .PIX_NUM(PN), .ADDR_W(AW)) b0 ();
  fetch_rf_1p_masked_if #(.PIXEL_WIDTH(PW), .PIX_NUM(PN), .ADDR_W(AW)) b1 ();

  fetch_rf_1p_masked #(.PIXEL_WIDTH(PW), .PIX_NUM(PN), .ADDR_W(AW), .DEPTH(64)) dut0 (
    .clk(clk), .rstn(rstn), .bus(b0)
  );
  fetch_rf_1p_masked #(.PIXEL_WIDTH(PW), .PIX_NUM(PN), .ADDR_W(AW), .DEPTH(48)) dut1 (
    .clk(clk), .rstn(rstn), .bus(b1)
  );

  typedef struct {
    logic          wr_en;
    logic [AW-1:0] wa;
    logic [PN-1:0] mask;
    logic [7:0]    wb;
    logic          wramp;
    logic          rd_en;
    logic [AW-1:0] ra;
    logic          e_wr;
    logic          e_rd;
    logic          e_vld;
    int            e_lo_n;
    logic [7:0]    e_lo;
    logic [7:0]    e_hi;
    logic          e_ramp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [W-1:0] pat(int lo_n, logic [7:0] lo, logic [7:0] hi, logic ramp);
    logic [W-1:0] v;
    for (int k = 0; k < PN; k++) begin
      if (ramp) v[k*PW +: PW] = 8'(k);
      else      v[k*PW +: PW] = (k < lo_n) ? lo : hi;
    end
    return v;
  endfunction

  function automatic void add(logic wr_en, logic [AW-1:0] wa, logic [PN-1:0] mask, logic [7:0] wb,
                              logic wramp, logic rd_en, logic [AW-1:0] ra, logic e_wr, logic e_rd,
                              logic e_vld, int e_lo_n, logic [7:0] e_lo, logic [7:0] e_hi, logic e_ramp);
    vec_t v;
    v.wr_en = wr_en; v.wa = wa; v.mask = mask; v.wb = wb; v.wramp = wramp;
    v.rd_en = rd_en; v.ra = ra; v.e_wr = e_wr; v.e_rd = e_rd; v.e_vld = e_vld;
    v.e_lo_n = e_lo_n; v.e_lo = e_lo; v.e_hi = e_hi; v.e_ramp = e_ramp;
    tbl.push_back(v);
  endfunction

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(logic wr_en, logic [AW-1:0] wa, logic [PN-1:0] mask, logic [W-1:0] wd,
                      logic rd_en, logic [AW-1:0] ra);
    b0.wr_en_i = wr_en; b0.wr_addr_i = wa; b0.wr_mask_i = mask; b0.wr_data_i = wd;
    b0.rd_en_i = rd_en; b0.rd_addr_i = ra;
  endtask

  task automatic drv1(logic wr_en, logic [AW-1:0] wa, logic [PN-1:0] mask, logic [W-1:0] wd,
                      logic rd_en, logic [AW-1:0] ra);
    b1.wr_en_i = wr_en; b1.wr_addr_i = wa; b1.wr_mask_i = mask; b1.wr_data_i = wd;
    b1.rd_en_i = rd_en; b1.rd_addr_i = ra;
  endtask

  initial begin
    // inputs: wr_en wa mask wb wramp rd_en ra | expected: wr_rdy rd_rdy vld lo_n lo hi ramp
    add(1, 5,  M_ALL,   8'h00, 1, 0, 0,  1, 0, 0, 0, 8'h00, 8'h00, 0);
    add(0, 0,  '0,      8'h00, 0, 1, 5,  1, 1, 0, 0, 8'h00, 8'h00, 0);
    add(0, 0,  '0,      8'h00, 0, 0, 0,  1, 1, 1, 0, 8'h00, 8'h00, 1);
    add(1, 9,  M_ALL,   8'hAA, 0, 0, 0,  1, 0, 0, 0, 8'h00, 8'h00, 1);
    add(1, 9,  48'hF,   8'h11, 0, 0, 0,  1, 0, 0, 0, 8'h00, 8'h00, 1);
    add(0, 0,  '0,      8'h00, 0, 0, 0,  0, 0, 0, 0, 8'h00, 8'h00, 1);
    add(0, 0,  '0,      8'h00, 0, 1, 9,  1, 1, 0, 0, 8'h00, 8'h00, 1);
    add(1, 9,  '0,      8'h55, 0, 0, 0,  1, 0, 1, 4, 8'h11, 8'hAA, 0);
    add(1, 10, M_ALL,   8'h33, 0, 1, 9,  1, 0, 0, 4, 8'h11, 8'hAA, 0);
    add(0, 0,  '0,      8'h00, 0, 1, 9,  1, 1, 0, 4, 8'h11, 8'hAA, 0);
    add(0, 0,  '0,      8'h00, 0, 1, 10, 1, 1, 1, 4, 8'h11, 8'hAA, 0);
    add(0, 0,  '0,      8'h00, 0, 0, 0,  1, 1, 1, 0, 8'h00, 8'h33, 0);
    add(0, 0,  '0,      8'h00, 0, 0, 0,  1, 1, 0, 0, 8'h00, 8'h33, 0);
    for (int k = 0; k < 8; k++)
      add(1, AW'(k), M_ALL, 8'h10 + 8'(k), 0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h33, 0);
    for (int k = 0; k < 8; k++)
      add(0, 0, '0, 8'h00, 0, 1, AW'(k), 1, 1, (k > 0), 0, 8'h00,
          (k == 0) ? 8'h33 : 8'h10 + 8'(k - 1), 0);
    add(0, 0,  '0,      8'h00, 0, 0, 0,  1, 1, 1, 0, 8'h00, 8'h17, 0);
    add(0, 0,  '0,      8'h00, 0, 0, 0,  1, 1, 0, 0, 8'h00, 8'h17, 0);

    drv0(1, 3, M_ALL, '1, 1, 3);
    drv1(0, 0, '0, '0, 0, 0);
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk1("rst_wr_rdy", b0.wr_rdy_o, 1'b0);
      chk1("rst_rd_rdy", b0.rd_rdy_o, 1'b0);
      chk1("rst_vld", b0.rd_vld_o, 1'b0);
      chkw("rst_data", b0.rd_data_o, '0);
    end
    rstn = 1'b0;
    drv0(0, 0, '0, '0, 0, 0);

    foreach (tbl[i]) begin
      tick();
      drv0(tbl[i].wr_en, tbl[i].wa, tbl[i].mask, pat(0, 8'h00, tbl[i].wb, tbl[i].wramp),
           tbl[i].rd_en, tbl[i].ra);
      #1;
      chk1($sformatf("row%0d_wr_rdy", i), b0.wr_rdy_o, tbl[i].e_wr);
      chk1($sformatf("row%0d_rd_rdy", i), b0.rd_rdy_o, tbl[i].e_rd);
      chk1($sformatf("row%0d_vld", i), b0.rd_vld_o, tbl[i].e_vld);
      chkw($sformatf("row%0d_data", i), b0.rd_data_o,
           pat(tbl[i].e_lo_n, tbl[i].e_lo, tbl[i].e_hi, tbl[i].e_ramp));
    end

    // reset landing in the RMW cycle must leave the word untouched
    tick(); drv0(1, 9, M_ALL, pat(0, 0, 8'hAA, 0), 0, 0);
    tick(); drv0(1, 9, 48'hF, pat(0, 0, 8'h11, 0), 0, 0);
    tick(); drv0(0, 0, '0, '0, 0, 0); rstn = 1'b1; #1;
    chk1("rmw_rst_wr_rdy", b0.wr_rdy_o, 1'b0);
    chk1("rmw_rst_rd_rdy", b0.rd_rdy_o, 1'b0);
    chkw("rmw_rst_data", b0.rd_data_o, '0);
    tick(); rstn = 1'b0; drv0(0, 0, '0, '0, 1, 9); #1;
    chk1("rmw_rst_idle", b0.rd_rdy_o, 1'b1);
    tick(); drv0(0, 0, '0, '0, 0, 0); #1;
    chk1("rmw_rst_rd_vld", b0.rd_vld_o, 1'b1);
    chkw("rmw_rst_word", b0.rd_data_o, pat(0, 0, 8'hAA, 0));

    // reset right after a read accept swallows the valid pulse
    tick(); drv0(0, 0, '0, '0, 1, 10);
    tick(); drv0(0, 0, '0, '0, 0, 0); rstn = 1'b1; #1;
    chk1("rd_rst_vld", b0.rd_vld_o, 1'b0);
    tick(); rstn = 1'b0; #1;
    chk1("rd_rst_vld_after", b0.rd_vld_o, 1'b0);
    chk1("rd_rst_wr_rdy", b0.wr_rdy_o, 1'b1);

    // out-of-range accesses on the 48-deep instance
    tick(); drv1(1, 2, M_ALL, pat(0, 0, 8'h22, 0), 0, 0);
    tick(); drv1(1, 50, M_ALL, pat(0, 0, 8'h99, 0), 0, 0); #1;
    chk1("oor_full_wr_rdy", b1.wr_rdy_o, 1'b1);
    tick(); drv1(1, 50, 48'hF, pat(0, 0, 8'h77, 0), 0, 0); #1;
    chk1("oor_part_wr_rdy", b1.wr_rdy_o, 1'b1);
    tick(); drv1(0, 0, '0, '0, 1, 2); #1;
    chk1("oor_no_rmw_wr_rdy", b1.wr_rdy_o, 1'b1);
    chk1("oor_no_rmw_rd_rdy", b1.rd_rdy_o, 1'b1);
    tick(); drv1(0, 0, '0, '0, 1, 63); #1;
    chk1("oor_alias_vld", b1.rd_vld_o, 1'b1);
    chkw("oor_alias_data", b1.rd_data_o, pat(0, 0, 8'h22, 0));
    tick(); drv1(0, 0, '0, '0, 0, 0); #1;
    chk1("oor_rd_vld", b1.rd_vld_o, 1'b1);
    chkw("oor_rd_data", b1.rd_data_o, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
